// File: rtl/ring_router_param_if.sv
// Handshake bundle between a ring router node and its CW/CCW neighbours and local PE.
// Pure wiring; no latency.
// Each channel is a valid/ready pair; ready flows opposite to valid and data.
interface ring_router_param_if #(
  parameter int DW = 64
);
  logic          cwsi;
  logic [DW-1:0] cwdi;
  logic          cwri;
  logic          cwso;
  logic [DW-1:0] cwdo;
  logic          cwro;
  logic          ccwsi;
  logic [DW-1:0] ccwdi;
  logic          ccwri;
  logic          ccwso;
  logic [DW-1:0] ccwdo;
  logic          ccwro;
  logic          pesi;
  logic [DW-1:0] pedi;
  logic          peri;
  logic          peso;
  logic [DW-1:0] pedo;
  logic          pero;
  logic          polarity;

  // Environment side: drives inbound flits and outbound readies.
  modport master (
    output cwsi, cwdi, cwro, ccwsi, ccwdi, ccwro, pesi, pedi, pero,
    input  cwri, cwso, cwdo, ccwri, ccwso, ccwdo, peri, peso, pedo, polarity
  );

  // Router side.
  modport slave (
    input  cwsi, cwdi, cwro, ccwsi, ccwdi, ccwro, pesi, pedi, pero,
    output cwri, cwso, cwdo, ccwri, ccwso, ccwdo, peri, peso, pedo, polarity
  );
endinterface

// File: rtl/ring_router_param.sv
// Bidirectional ring node: per-input FIFOs, hop-count routing, round-robin output registers.
// Latency: 2 cycles inbound handshake to outbound valid (FIFO write, then output register load).
// Backpressure: inbound ready = FIFO not full (registered only); outputs hold until accepted.
module ring_router_param #(
  parameter int DW    = 64,
  parameter int HOPW  = 4,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  ring_router_param_if.slave io
);
  localparam int AW      = $clog2(DEPTH);
  localparam int HOP_MSB = DW - 2;
  // Source / output indices.
  localparam int CW  = 0;
  localparam int CCW = 1;
  localparam int PE  = 2;
  localparam logic [AW:0]     FULL    = (AW + 1)'(DEPTH);
  localparam logic [HOPW-1:0] HOP_ONE = HOPW'(1);

  logic [DW-1:0] mem_q [3][DEPTH];
  logic [DW-1:0] mem_d [3][DEPTH];
  logic [AW-1:0] rd_q  [3];
  logic [AW-1:0] rd_d  [3];
  logic [AW-1:0] wr_q  [3];
  logic [AW-1:0] wr_d  [3];
  logic [AW:0]   cnt_q [3];
  logic [AW:0]   cnt_d [3];
  logic [2:0]    vld_q, vld_d;
  logic [DW-1:0] dat_q [3];
  logic [DW-1:0] dat_d [3];
  // ptr_cw/ptr_ccw: 0 = ring source has priority, 1 = pe has priority.
  logic          ptr_cw_q, ptr_cw_d, ptr_ccw_q, ptr_ccw_d;
  // ptr_pe: index of the highest-priority source (cw, ccw, pe).
  logic [1:0]    ptr_pe_q, ptr_pe_d;
  logic          polarity_q, polarity_d;

  logic [2:0]    in_vld, in_rdy, out_rdy, push, pop, load, gv;
  logic [DW-1:0] in_dat [3];
  logic [DW-1:0] head   [3];
  logic [DW-1:0] fwd    [3];
  logic [2:0]    req    [3];  // req[output][source]
  logic [1:0]    gnt    [3];

  assign in_vld    = {io.pesi, io.ccwsi, io.cwsi};
  assign in_dat[0] = io.cwdi;
  assign in_dat[1] = io.ccwdi;
  assign in_dat[2] = io.pedi;
  assign out_rdy   = {io.pero, io.ccwro, io.cwro};

  assign io.cwri     = in_rdy[CW];
  assign io.ccwri    = in_rdy[CCW];
  assign io.peri     = in_rdy[PE];
  assign io.cwso     = vld_q[CW];
  assign io.ccwso    = vld_q[CCW];
  assign io.peso     = vld_q[PE];
  assign io.cwdo     = dat_q[CW];
  assign io.ccwdo    = dat_q[CCW];
  assign io.pedo     = dat_q[PE];
  assign io.polarity = polarity_q;

  // Decode each FIFO head into an output request; ring forwards carry hop-1.
  always_comb begin
    for (int o = 0; o < 3; o++) req[o] = '0;
    for (int s = 0; s < 3; s++) begin
      in_rdy[s] = (cnt_q[s] != FULL);
      push[s]   = in_vld[s] & in_rdy[s];
      head[s]   = mem_q[s][rd_q[s]];
      fwd[s]    = head[s];
      fwd[s][HOP_MSB -: HOPW] = head[s][HOP_MSB -: HOPW] - HOP_ONE;
      if (cnt_q[s] != '0) begin
        if (head[s][HOP_MSB -: HOPW] == '0) req[PE][s] = 1'b1;
        else if (s == PE) req[head[s][DW-1] ? CCW : CW][s] = 1'b1;
        else req[s][s] = 1'b1;
      end
    end
  end

  // Round-robin grant per output, pops, output register and FIFO next state.
  always_comb begin
    int idx;
    idx  = 0;
    load = ~vld_q | out_rdy;

    gv[CW]   = load[CW] & (req[CW][CW] | req[CW][PE]);
    gnt[CW]  = (req[CW][PE] && (!req[CW][CW] || ptr_cw_q)) ? 2'd2 : 2'd0;
    gv[CCW]  = load[CCW] & (req[CCW][CCW] | req[CCW][PE]);
    gnt[CCW] = (req[CCW][PE] && (!req[CCW][CCW] || ptr_ccw_q)) ? 2'd2 : 2'd1;
    gv[PE]   = load[PE] & (|req[PE]);
    gnt[PE]  = 2'd0;
    // Walk from lowest to highest priority so the last hit is the winner.
    for (int k = 2; k >= 0; k--) begin
      idx = (int'(ptr_pe_q) + k) % 3;
      if (req[PE][idx]) gnt[PE] = 2'(idx);
    end

    pop = '0;
    for (int o = 0; o < 3; o++) begin
      vld_d[o] = vld_q[o];
      dat_d[o] = dat_q[o];
      if (gv[o]) pop[gnt[o]] = 1'b1;
      if (load[o]) begin
        vld_d[o] = gv[o];
        if (gv[o]) dat_d[o] = (o == PE || gnt[o] == 2'd2) ? head[gnt[o]] : fwd[gnt[o]];
      end
    end

    ptr_cw_d   = gv[CW]  ? (gnt[CW] == 2'd0)  : ptr_cw_q;
    ptr_ccw_d  = gv[CCW] ? (gnt[CCW] == 2'd1) : ptr_ccw_q;
    ptr_pe_d   = gv[PE]  ? ((gnt[PE] == 2'd2) ? 2'd0 : gnt[PE] + 2'd1) : ptr_pe_q;
    polarity_d = ~polarity_q;

    for (int s = 0; s < 3; s++) begin
      mem_d[s] = mem_q[s];
      wr_d[s]  = wr_q[s];
      rd_d[s]  = rd_q[s];
      cnt_d[s] = cnt_q[s];
      if (push[s]) begin
        mem_d[s][wr_q[s]] = in_dat[s];
        wr_d[s] = wr_q[s] + 1'b1;
      end
      if (pop[s]) rd_d[s] = rd_q[s] + 1'b1;
      if (push[s] && !pop[s]) cnt_d[s] = cnt_q[s] + 1'b1;
      else if (!push[s] && pop[s]) cnt_d[s] = cnt_q[s] - 1'b1;
    end
  end

  // State registers; reset drops every buffered and in-flight flit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 3; s++) begin
        for (int i = 0; i < DEPTH; i++) mem_q[s][i] <= '0;
        rd_q[s]  <= '0;
        wr_q[s]  <= '0;
        cnt_q[s] <= '0;
        dat_q[s] <= '0;
      end
      vld_q      <= '0;
      ptr_cw_q   <= 1'b0;
      ptr_ccw_q  <= 1'b0;
      ptr_pe_q   <= 2'd0;
      polarity_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      dat_q      <= dat_d;
      vld_q      <= vld_d;
      ptr_cw_q   <= ptr_cw_d;
      ptr_ccw_q  <= ptr_ccw_d;
      ptr_pe_q   <= ptr_pe_d;
      polarity_q <= polarity_d;
    end
  end
endmodule

// File: doc/ring_router_param.md
Name: ring_router_param

Overview:
Parametrised successor to the four-port ring router node. Connects one PE to a bidirectional ring (CW and CCW links). Each input has a DEPTH-entry FIFO, and forwarding is driven by a hop count carried in the header. Each output has round-robin arbitration and valid/ready handshakes, so a ring of any size is built by chaining instances.

Parameters:
DW, 64, flit width in bits (≥ HOPW+2)
HOPW, 4, hop-count field width
DEPTH, 4, entries per input FIFO (power of two, ≥2)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
cwsi  input  1  CW inbound valid
cwdi  input  DW  CW inbound flit
cwri  output  1  CW inbound ready (to upstream)
cwso  output  1  CW outbound valid
cwdo  output  DW  CW outbound flit
cwro  input  1  CW outbound ready (from downstream)
ccwsi/ccwdi/ccwri  input/input/output  1/DW/1  CCW inbound, same rules as CW
ccwso/ccwdo/ccwro  output/output/input  1/DW/1  CCW outbound, same rules as CW
pesi  input  1  PE injection valid
pedi  input  DW  PE injection flit
peri  output  1  PE injection ready
peso  output  1  PE ejection valid
pedo  output  DW  PE ejection flit
pero  input  1  PE ejection ready
polarity  output  1  even/odd cycle indicator

Behaviour:
- Flit header: bit DW-1 = dir (0 = CW, 1 = CCW); bits [DW-2 -: HOPW] = hop count; remaining bits are payload, carried unchanged.
- Handshake: a transfer occurs on a rising edge when valid and ready are both high.
  - Inbound ready = FIFO not full, derived from registered occupancy only. Never combinational from any downstream ready.
  - Outbound valid and data come straight from an output register. Once raised, valid and data hold stable until accepted.
- FIFOs: three (cw, ccw, pe), DEPTH entries each.
  - Simultaneous push and pop when full is illegal, because ready is low.
  - Simultaneous push and pop when empty is allowed: the flit is written, and it is not bypassed.
- Routing of a FIFO head:
  - Ring head (cw or ccw) with hop == 0: destined for the PE output.
  - Ring head with hop != 0: forwarded out the same direction with hop decremented by 1.
  - PE head with hop != 0: sent to the output selected by dir, hop unchanged. The injector sets hop = distance-1.
  - PE head with hop == 0: local loopback to the PE output.
- Output register load: an output register loads on an edge if it is empty, or if it is being accepted on that same edge (a full-throughput bubble-free path).
- Arbitration, one round-robin pointer per output:
  - CW out: contenders are cw FIFO and pe FIFO.
  - CCW out: contenders are ccw FIFO and pe FIFO.
  - PE out: contenders are cw, ccw, pe, in rotation order cw→ccw→pe.
  - A pointer advances past the granted source only when a grant occurs. A lone requester is granted regardless of the pointer.
  - A FIFO head pops only in the cycle its output register loads it. At most one pop per FIFO per cycle.
- Minimum latency: inbound handshake at edge t → flit visible on the output from after edge t+1, i.e. 2 cycles.
- polarity: 0 after reset, toggles every clock. It is informational for PE-side scheduling.
- Reset, asynchronous: all FIFOs emptied; cwso, ccwso, peso = 0; cwdo, ccwdo, pedo = 0; cwri, ccwri, peri = 1 after release; polarity = 0; all round-robin pointers select the first listed contender.
  - Reset mid-transfer drops all in-flight flits; no partial state survives.
- Back-pressure: while an output's ready is low, its register holds, its sources stall, and their FIFOs fill. Inbound ready falls exactly when occupancy reaches DEPTH.

Test Plan:
- Reset then idle: assert rst mid-cycle → all *so = 0, all *ri = 1 immediately after release, polarity toggles 0,1,0,… each cycle.
- Forward: cwdi with dir = 0, hop = 3, payload 0xABCD at edge 0 → cwso = 1 with hop = 2, payload 0xABCD visible after edge 1; peso stays 0.
- Eject and loopback: ccwdi with hop = 0 → pedo equals that flit 2 cycles later. Then pedi with hop = 0, dir = 1 → appears on pedo, not on ccwdo.
- Contention: cw FIFO and pe FIFO both hold CW-bound flits every cycle, cwro = 1 → cwdo alternates ring, pe, ring, pe…; 3-way PE-out contention yields cw, ccw, pe rotation.
- Back-pressure: cwro = 0 and 5 cw flits forwarded with DEPTH = 4 → 1 flit held in output register, FIFO full, cwri = 0 after 5th accept. Raise cwro → all 5 delivered in order, one per cycle, with no drops or duplicates.
- Parameter sweep: DW = 32, HOPW = 3, DEPTH = 2 → same scenarios pass; hop = 7 decrements to 6; cwri drops after 2 buffered + 1 registered flit.
